// File: rtl/fir_axis_pkg.sv
// Shared defaults and types for the FIR AXI-Stream output stage.
package fir_axis_pkg;

  localparam int P_DATA_WIDTH = 32;
  localparam int P_DEPTH      = 16;

  typedef struct packed {
    logic                    last;
    logic [P_DATA_WIDTH-1:0] data;
  } beat_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_axis_out_fifo_if.sv
// AXI-Stream beat channel (valid/data/last/ready) shared by the FIFO input and output sides.
interface fir_axis_out_fifo_if
  import fir_axis_pkg::*;
#(
  parameter int pDATA_WIDTH = P_DATA_WIDTH
) ();

  logic                   tvalid;
  logic [pDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic                   tready;

  modport master (output tvalid, output tdata, output tlast, input  tready);
  modport slave  (input  tvalid, input  tdata, input  tlast, output tready);

endinterface

// File: rtl/fir_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fir_fifo_mem
  import fir_axis_pkg::*;
#(
  parameter int pWIDTH  = P_DATA_WIDTH + 1,
  parameter int pDEPTH  = P_DEPTH,
  parameter int pADDR_W = clog2(P_DEPTH)
) (
  input  logic               axis_clk,
  input  logic               we,
  input  logic [pADDR_W-1:0] waddr,
  input  logic [pWIDTH-1:0]  wdata,
  input  logic [pADDR_W-1:0] raddr,
  output logic [pWIDTH-1:0]  rdata
);

  logic [pWIDTH-1:0] mem [pDEPTH];

  always_ff @(posedge axis_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_axis_out_fifo.sv
// FWFT output FIFO between the FIR result port and the downstream consumer,
// with occupancy, almost-full and completed-frame tracking.
module fir_axis_out_fifo
  import fir_axis_pkg::*;
#(
  parameter int pDATA_WIDTH = P_DATA_WIDTH,
  parameter int pDEPTH      = P_DEPTH,
  parameter int pPTR_W      = clog2(pDEPTH),
  parameter int pAFULL_TH   = 12
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst_n,
  input  logic                 clear,
  fir_axis_out_fifo_if.slave   s_axis,
  fir_axis_out_fifo_if.master  m_axis,
  output logic [pPTR_W:0]      level,
  output logic                 almost_full,
  output logic [31:0]          frame_cnt,
  output logic                 frame_done
);

  localparam logic [pPTR_W:0] PTR_ONE  = (pPTR_W+1)'(1);
  localparam logic [pPTR_W:0] AFULL_TH = (pPTR_W+1)'(pAFULL_TH);

  logic [pPTR_W:0]      wr_ptr;
  logic [pPTR_W:0]      rd_ptr;
  logic                 rst_done;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 s_ready;
  logic [pDATA_WIDTH:0] rd_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[pPTR_W] != rd_ptr[pPTR_W]) &&
                 (wr_ptr[pPTR_W-1:0] == rd_ptr[pPTR_W-1:0]);

  assign s_ready       = rst_done & ~full & ~clear;
  assign s_axis.tready = s_ready;
  assign push          = s_axis.tvalid & s_ready;

  // clear wins over a pop in the same cycle, so a head beat dropped by
  // clear never counts as a completed frame.
  assign pop = ~empty & m_axis.tready & ~clear;

  assign m_axis.tvalid = ~empty;
  assign m_axis.tdata  = empty ? '0 : rd_word[pDATA_WIDTH-1:0];
  assign m_axis.tlast  = ~empty & rd_word[pDATA_WIDTH];

  assign almost_full = (level >= AFULL_TH);

  fir_fifo_mem #(
    .pWIDTH  (pDATA_WIDTH + 1),
    .pDEPTH  (pDEPTH),
    .pADDR_W (pPTR_W)
  ) u_mem (
    .axis_clk (axis_clk),
    .we       (push),
    .waddr    (wr_ptr[pPTR_W-1:0]),
    .wdata    ({s_axis.tlast, s_axis.tdata}),
    .raddr    (rd_ptr[pPTR_W-1:0]),
    .rdata    (rd_word)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop & m_axis.tlast;
      if (pop && m_axis.tlast) frame_cnt <= frame_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fir_axis_out_fifo.sv
// Directed bench for fir_axis_out_fifo: pass-through, fill/drain, full
// collision, steady-state wrap, clear and async reset.
module tb_fir_axis_out_fifo;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        clear;
  logic [4:0]  level;
  logic        almost_full;
  logic [31:0] frame_cnt;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  fir_axis_out_fifo_if #(.pDATA_WIDTH(32)) s_if ();
  fir_axis_out_fifo_if #(.pDATA_WIDTH(32)) m_if ();

  fir_axis_out_fifo #(
    .pDATA_WIDTH (32),
    .pDEPTH      (16),
    .pPTR_W      (4),
    .pAFULL_TH   (12)
  ) dut (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .clear       (clear),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .level       (level),
    .almost_full (almost_full),
    .frame_cnt   (frame_cnt),
    .frame_done  (frame_done)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, landing mid-cycle for drive and sample.
  task automatic tick();
    @(posedge axis_clk);
    #2;
  endtask

  initial begin
    axis_rst_n = 1'b0;
    clear      = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;

    // Reset state
    #1;
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_level", level, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_afull", almost_full, 0);
    @(posedge axis_clk);
    @(posedge axis_clk);
    #2;
    axis_rst_n = 1'b1;
    #1;
    chk("rel_s_tready_early", s_if.tready, 0);
    tick();
    chk("rel_s_tready", s_if.tready, 1);
    chk("rel_m_tvalid", m_if.tvalid, 0);
    chk("rel_level", level, 0);

    // Pass-through of a 5-beat frame
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      s_if.tdata = 32'(k);
      s_if.tlast = (k == 5);
      tick();
      chk("pt_m_tdata", m_if.tdata, 64'(k));
      chk("pt_m_tlast", m_if.tlast, (k == 5) ? 64'd1 : 64'd0);
      chk("pt_level", level, 1);
      chk("pt_frame_done_low", frame_done, 0);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    tick();
    chk("pt_frame_done", frame_done, 1);
    chk("pt_frame_cnt", frame_cnt, 1);
    chk("pt_empty", m_if.tvalid, 0);
    tick();
    chk("pt_frame_done_pulse", frame_done, 0);

    // Fill with 20 offered beats while stalled, then drain
    m_if.tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_if.tdata  = 32'h100 + 32'(i);
      s_if.tvalid = 1'b1;
      #1;
      chk("fill_s_tready", s_if.tready, (i < 16) ? 64'd1 : 64'd0);
      tick();
      chk("fill_level", level, (i < 16) ? 64'(i + 1) : 64'd16);
      chk("fill_afull", almost_full, (i >= 11) ? 64'd1 : 64'd0);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_m_tvalid", m_if.tvalid, 1);
      chk("drain_m_tdata", m_if.tdata, 64'h100 + 64'(i));
      tick();
    end
    chk("drain_level", level, 0);
    chk("drain_m_tvalid_end", m_if.tvalid, 0);
    chk("drain_frame_cnt", frame_cnt, 1);

    // Full FIFO with push and pop offered together
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_if.tdata  = 32'h200 + 32'(i);
      s_if.tvalid = 1'b1;
      tick();
    end
    chk("full_level", level, 16);
    chk("full_s_tready", s_if.tready, 0);
    s_if.tdata  = 32'hDEAD;
    m_if.tready = 1'b1;
    chk("full_head", m_if.tdata, 64'h200);
    tick();
    chk("coll_level", level, 15);
    chk("coll_s_tready", s_if.tready, 1);
    s_if.tvalid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk("coll_drain", m_if.tdata, 64'h200 + 64'(i));
      tick();
    end
    chk("coll_no_push", m_if.tvalid, 0);

    // Steady state at level 7 across pointer wrap
    m_if.tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_if.tdata  = 32'h300 + 32'(i);
      s_if.tvalid = 1'b1;
      tick();
    end
    chk("ss_level_start", level, 7);
    m_if.tready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      s_if.tdata = 32'h307 + 32'(j);
      chk("ss_m_tdata", m_if.tdata, 64'h300 + 64'(j));
      tick();
      chk("ss_level", level, 7);
    end
    s_if.tvalid = 1'b0;
    for (int j = 10; j < 17; j++) begin
      chk("ss_drain", m_if.tdata, 64'h300 + 64'(j));
      tick();
    end
    chk("ss_empty", m_if.tvalid, 0);

    // clear at level 9 with a tlast beat at the head
    m_if.tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_if.tdata  = 32'h400 + 32'(i);
      s_if.tlast  = (i == 0);
      s_if.tvalid = 1'b1;
      tick();
    end
    s_if.tlast = 1'b0;
    chk("clr_level_pre", level, 9);
    chk("clr_head_tlast", m_if.tlast, 1);
    clear       = 1'b1;
    s_if.tdata  = 32'h4FF;
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    #1;
    chk("clr_s_tready", s_if.tready, 0);
    tick();
    clear       = 1'b0;
    s_if.tvalid = 1'b0;
    chk("clr_level", level, 0);
    chk("clr_m_tvalid", m_if.tvalid, 0);
    chk("clr_frame_cnt", frame_cnt, 1);
    tick();
    chk("clr_no_push", m_if.tvalid, 0);
    chk("clr_frame_done", frame_done, 0);

    // Async reset mid-frame
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_if.tdata  = 32'h500 + 32'(i);
      s_if.tvalid = 1'b1;
      tick();
    end
    s_if.tvalid = 1'b0;
    chk("ar_level_pre", level, 3);
    axis_rst_n = 1'b0;
    #1;
    chk("ar_m_tvalid", m_if.tvalid, 0);
    chk("ar_m_tdata", m_if.tdata, 0);
    chk("ar_level", level, 0);
    chk("ar_s_tready", s_if.tready, 0);
    chk("ar_frame_cnt", frame_cnt, 0);
    tick();
    chk("ar_hold_s_tready", s_if.tready, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_axis_out_fifo.md
Name: fir_axis_out_fifo

Overview:
Downstream output stage for the FIR engine. Captures the FIR AXI-Stream result port (sm_tvalid/sm_tdata/sm_tlast/sm_tready) into a small first-word-fall-through FIFO, so short consumer stalls do not back-pressure the FIR accumulate loop. Re-emits results on a master AXI-Stream port with tlast preserved. Exposes occupancy, almost-full and a completed-frame counter for the testbench/host.

Parameters:
pDATA_WIDTH, 32, stream data width
pDEPTH, 16, FIFO entries; power of two, >=4
pPTR_W, 4, log2(pDEPTH)
pAFULL_TH, 12, almost_full asserted when level >= this value

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  reset, asynchronous, active-low
clear  in  1  synchronous flush request, one-cycle pulse
s_tvalid  in  1  input beat valid (from FIR sm_tvalid)
s_tdata  in  pDATA_WIDTH  input data (from FIR sm_tdata)
s_tlast  in  1  last beat of frame (from FIR sm_tlast)
s_tready  out  1  FIFO can accept a beat (to FIR sm_tready)
m_tvalid  out  1  output beat valid
m_tdata  out  pDATA_WIDTH  output data
m_tlast  out  1  output last flag
m_tready  in  1  consumer ready
level  out  pPTR_W+1  current occupancy, 0..pDEPTH
almost_full  out  1  level >= pAFULL_TH
frame_cnt  out  32  number of tlast beats popped since reset
frame_done  out  1  one-cycle pulse on each tlast pop

Behaviour:
- Single clock axis_clk; reset asynchronous, active-low on axis_rst_n; every flop is reset by it.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, almost_full=0, frame_cnt=0, frame_done=0. Storage array is not reset.
- rst_done flop: 0 in reset, 1 from the first rising edge after release. s_tready = rst_done & ~full & ~clear.
- Pointers are pPTR_W+1 bits. empty = (wr_ptr==rd_ptr). full = MSBs differ and lower bits equal. Wrap is natural modulo 2*pDEPTH.
- push = s_tvalid & s_tready. Stores {s_tlast, s_tdata} at wr_ptr[pPTR_W-1:0] and increments wr_ptr.
- pop = m_tvalid & m_tready. Increments rd_ptr.
- FWFT timing: m_tvalid = ~empty. m_tdata/m_tlast come combinationally from the entry at rd_ptr, and are forced to 0 when empty.
- Latency: a beat pushed at edge N is presented with m_tvalid=1 after edge N. Zero bubbles at steady state.
- level: registered. +1 on push only, -1 on pop only, unchanged on both or neither. almost_full is decoded from level.
- Full with push and pop attempted together: s_tready=0, so only the pop occurs.
- Empty: m_tvalid=0, so no pop. A push alone occurs.
- AXI rules:
  - m_tvalid, once high, stays high with m_tdata/m_tlast stable until pop, except on clear.
  - s_tready may drop only when full or clear.
- frame_done = registered (pop & m_tlast), high exactly one cycle after the tlast pop.
- frame_cnt increments on the same edge and wraps at 2^32.
- clear has priority over push and pop in its cycle:
  - wr_ptr=rd_ptr=0 and level=0; m_tvalid=0 from the next cycle.
  - No push is accepted that cycle (s_tready=0).
  - frame_cnt is retained.
- Reset asserted mid-frame: all state returns to reset values immediately (async). Partially queued frames are discarded.
- No data-width arithmetic; data passes bit-exact.

Decomposition:
- Shared package fir_axis_pkg: pDATA_WIDTH default, FIFO depth default, clog2 function, and a beat struct {last, data}.
- One sub-module, fir_fifo_mem: pDEPTH x (pDATA_WIDTH+1) register file with one synchronous write port and one asynchronous read port.
- Pointer, level and frame logic live in fir_axis_out_fifo.

Test Plan:
- Reset release, no traffic -> s_tready=0 in reset, 1 one cycle after release; m_tvalid=0, level=0.
- Push 0x1..0x5 (tlast on 0x5) with m_tready=1 -> m_tdata 0x1..0x5 in order, each one cycle after push; m_tlast only on 0x5; frame_done pulses once; frame_cnt=1.
- m_tready=0, push 20 beats -> 16 accepted; s_tready=0 at level=16; almost_full=1 from level=12. Then m_tready=1 -> 16 beats out in order, level returns to 0.
- Full FIFO with s_tvalid=1 and m_tready=1 in the same cycle -> one pop, no push, level=15; s_tready=1 next cycle.
- Level 7 with concurrent push and pop for 10 cycles -> level stays 7; output order matches input across pointer wrap.
- clear at level 9 while s_tvalid=1 -> beat not accepted, level=0, m_tvalid=0 next cycle, frame_cnt unchanged. Async reset mid-frame -> all outputs 0 immediately.
